// File: rtl/psx_button_events_pkg.sv
// Shared definitions for the PSX button event path: button bit indices,
// event field widths and the scan FSM encoding.
package psx_button_events_pkg;

  localparam int NUM_BTN   = 16;
  localparam int BTN_IDX_W = 4;
  localparam int EV_W      = BTN_IDX_W + 1;
  localparam int DEB_CNT_W = 3;

  localparam int BTN_SELECT   = 0;
  localparam int BTN_START    = 3;
  localparam int BTN_UP       = 4;
  localparam int BTN_RIGHT    = 5;
  localparam int BTN_DOWN     = 6;
  localparam int BTN_LEFT     = 7;
  localparam int BTN_TRIANGLE = 12;
  localparam int BTN_CIRCLE   = 13;
  localparam int BTN_CROSS    = 14;
  localparam int BTN_SQUARE   = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [BTN_IDX_W-1:0] lowest_set(input logic [NUM_BTN-1:0] v);
    lowest_set = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = BTN_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/psx_event_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit
// so full and empty are distinguishable. Read data is zero while empty.
module psx_event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_rd;
  logic             do_wr;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd    = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    do_wr    = wr_en & (~full | do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/psx_button_events.sv
// Samples the active-low PSX button word, debounces each bit, drives game
// controls and queues press/release events into a small FWFT FIFO.
//
// state   | meaning
// ST_IDLE | no debounced changes waiting to be reported
// ST_SCAN | pending mask non-empty; one event pushed per cycle, lowest index first
module psx_button_events
  import psx_button_events_pkg::*;
#(
  parameter int SAMPLE_PERIOD    = 32000,
  parameter int DEBOUNCE_SAMPLES = 2,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTN-1:0]  button_state,
  output logic [NUM_BTN-1:0]  pressed,
  output logic                jump,
  output logic                duck,
  output logic                ev_valid,
  output logic [EV_W-1:0]     ev_data,
  input  logic                ev_ready,
  output logic                overflow
);

  localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CW-1:0]        TICK_AT  = CW'(SAMPLE_PERIOD - 1);
  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE_SAMPLES - 1);

  logic [CW-1:0]                    smp_cnt_q, smp_cnt_d;
  logic                             tick;
  logic [NUM_BTN-1:0]               pressed_q, pressed_d;
  logic [NUM_BTN-1:0]               pending_q, pending_d;
  logic [NUM_BTN-1:0][DEB_CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [NUM_BTN-1:0]               accept;
  scan_state_e                      state_q, state_d;
  logic                             overflow_q, overflow_d;

  logic                 push;
  logic [BTN_IDX_W-1:0] scan_idx;
  logic [EV_W-1:0]      push_data;
  logic                 fifo_empty;
  logic                 fifo_full;

  // Sample timer and per-bit debounce.
  always_comb begin
    tick      = (smp_cnt_q == TICK_AT);
    smp_cnt_d = tick ? '0 : smp_cnt_q + 1'b1;
    pressed_d = pressed_q;
    deb_cnt_d = deb_cnt_q;
    accept    = '0;
    if (tick) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (~button_state[i] == pressed_q[i]) begin
          deb_cnt_d[i] = '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          pressed_d[i] = ~button_state[i];
          deb_cnt_d[i] = '0;
          accept[i]    = 1'b1;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Scan FSM: SCAN is held exactly while pending bits remain.
  always_comb begin
    push      = (state_q == ST_SCAN);
    scan_idx  = lowest_set(pending_q);
    push_data = {pressed_q[scan_idx], scan_idx};
    pending_d = pending_q;
    if (push) pending_d[scan_idx] = 1'b0;
    pending_d = pending_d | accept;
    state_d   = state_q;
    case (state_q)
      ST_IDLE: if (pending_d != '0) state_d = ST_SCAN;
      ST_SCAN: if (pending_d == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Full with no pop this cycle means the event is lost.
    overflow_d = overflow_q | (push & fifo_full & ~ev_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_cnt_q  <= '0;
      pressed_q  <= '0;
      pending_q  <= '0;
      deb_cnt_q  <= '0;
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
    end else begin
      smp_cnt_q  <= smp_cnt_d;
      pressed_q  <= pressed_d;
      pending_q  <= pending_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  psx_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (ev_ready),
    .rd_data (ev_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    pressed  = pressed_q;
    jump     = pressed_q[BTN_UP] | pressed_q[BTN_CROSS];
    duck     = pressed_q[BTN_DOWN] & ~jump;
    ev_valid = ~fifo_empty;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_psx_button_events.sv
// Bench for psx_button_events: a sample/debounce/event-queue model checked
// every cycle, plus directed scenarios with literal expected events.
module tb_psx_button_events;

  localparam int SP    = 4;
  localparam int DEB   = 2;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] button_state;
  logic [15:0] pressed;
  logic        jump;
  logic        duck;
  logic        ev_valid;
  logic [4:0]  ev_data;
  logic        ev_ready;
  logic        overflow;

  psx_button_events #(
    .SAMPLE_PERIOD    (SP),
    .DEBOUNCE_SAMPLES (DEB),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_state (button_state),
    .pressed      (pressed),
    .jump         (jump),
    .duck         (duck),
    .ev_valid     (ev_valid),
    .ev_data      (ev_data),
    .ev_ready     (ev_ready),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [15:0] m_pressed;
  logic [15:0] m_pend;
  int          m_cnt [16];
  int          m_phase;
  logic        m_ovf;
  logic [4:0]  m_q [$];
  logic [4:0]  pop_log [$];
  int          m_k;
  logic [4:0]  m_ev;
  logic        m_push;
  logic        m_pop;

  always @(posedge clk) begin
    if (rst_n && ev_valid && ev_ready) pop_log.push_back(ev_data);
    if (!rst_n) begin
      m_q.delete();
      m_pressed = '0;
      m_pend    = '0;
      m_phase   = 0;
      m_ovf     = 1'b0;
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    end else begin
      m_pop  = (m_q.size() > 0) && ev_ready;
      m_push = (m_pend != 0);
      m_ev   = '0;
      if (m_push) begin
        m_k = 0;
        while (!m_pend[m_k]) m_k++;
        m_ev = {m_pressed[m_k], 4'(m_k)};
        m_pend[m_k] = 1'b0;
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_ev);
        else m_ovf = 1'b1;
      end
      if (m_phase == SP - 1) begin
        for (int i = 0; i < 16; i++) begin
          if (~button_state[i] == m_pressed[i]) m_cnt[i] = 0;
          else if (m_cnt[i] + 1 == DEB) begin
            m_pressed[i] = ~button_state[i];
            m_cnt[i]     = 0;
            m_pend[i]    = 1'b1;
          end else m_cnt[i] = m_cnt[i] + 1;
        end
      end
      m_phase = (m_phase + 1) % SP;
    end
  end

  int total;
  int bad;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_log(input string name, input int base, input logic [4:0] exp [$]);
    chk({name, "_count"}, 16'(pop_log.size() - base), 16'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < pop_log.size()) chk(name, {11'd0, pop_log[base + i]}, {11'd0, exp[i]});
    end
  endtask

  task automatic rand_ready(input int n);
    for (int i = 0; i < n; i++) begin
      ev_ready = 1'($urandom_range(0, 1));
      cyc(1);
    end
  endtask

  logic        exp_jump;
  logic        exp_duck;
  int          base;
  int          guard;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    button_state = 16'h0000;
    ev_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        exp_jump = m_pressed[4] | m_pressed[14];
        exp_duck = m_pressed[6] & ~exp_jump;
        chk("pressed", pressed, m_pressed);
        chk("jump", {15'd0, jump}, {15'd0, exp_jump});
        chk("duck", {15'd0, duck}, {15'd0, exp_duck});
        chk("ev_valid", {15'd0, ev_valid}, {15'd0, m_q.size() > 0});
        chk("ev_data", {11'd0, ev_data}, {11'd0, (m_q.size() > 0) ? m_q[0] : 5'd0});
        chk("overflow", {15'd0, overflow}, {15'd0, m_ovf});
      end
    join_none

    // Reset with every button held down
    cyc(3);
    chk("rst_pressed", pressed, 16'h0000);
    chk("rst_valid", {15'd0, ev_valid}, 16'd0);
    chk("rst_ovf", {15'd0, overflow}, 16'd0);
    rst_n = 1'b1;
    cyc(6);
    chk("one_tick_no_event", {15'd0, ev_valid}, 16'd0);
    chk("one_tick_pressed", pressed, 16'h0000);
    cyc(30);
    chk("all_pressed", pressed, 16'hFFFF);
    chk("all_ovf", {15'd0, overflow}, 16'd1);
    chk("all_head", {11'd0, ev_data}, 16'h0010);

    // Fresh reset with everything released
    rst_n = 1'b0;
    button_state = 16'hFFFF;
    cyc(3);
    rst_n = 1'b1;
    ev_ready = 1'b1;
    cyc(8);

    // CROSS press / release
    base = pop_log.size();
    button_state = 16'hBFFF;
    cyc(12);
    chk("cross_pressed", pressed, 16'h4000);
    chk("cross_jump", {15'd0, jump}, 16'd1);
    button_state = 16'hFFFF;
    cyc(12);
    chk_log("cross_ev", base, '{5'h1E, 5'h0E});

    // DOWN glitch, then a real DOWN press
    base = pop_log.size();
    button_state = 16'hFFBF;
    cyc(4);
    button_state = 16'hFFFF;
    cyc(12);
    chk("glitch_pressed", pressed, 16'h0000);
    chk("glitch_duck", {15'd0, duck}, 16'd0);
    chk_log("glitch_ev", base, '{});
    button_state = 16'hFFBF;
    cyc(16);
    chk("down_pressed", pressed, 16'h0040);
    chk("down_duck", {15'd0, duck}, 16'd1);
    button_state = 16'hFFFF;
    cyc(12);
    chk_log("down_ev", base, '{5'h16, 5'h06});

    // Six buttons change on the same sample
    base = pop_log.size();
    button_state = 16'h0FAF;
    cyc(20);
    chk("multi_pressed", pressed, 16'hF050);
    chk("multi_duck", {15'd0, duck}, 16'd0);
    button_state = 16'hFFFF;
    cyc(20);
    chk_log("multi_ev", base,
            '{5'h14, 5'h16, 5'h1C, 5'h1D, 5'h1E, 5'h1F, 5'h04, 5'h06, 5'h0C, 5'h0D, 5'h0E, 5'h0F});
    chk("multi_ovf", {15'd0, overflow}, 16'd0);

    // Overflow with the consumer stalled
    ev_ready = 1'b0;
    base = pop_log.size();
    button_state = 16'h0FAF;
    cyc(20);
    chk("ovf_flag", {15'd0, overflow}, 16'd1);
    chk("ovf_head", {11'd0, ev_data}, 16'h0014);
    cyc(10);
    chk("ovf_head_hold", {11'd0, ev_data}, 16'h0014);
    ev_ready = 1'b1;
    cyc(4);
    ev_ready = 1'b0;
    chk_log("ovf_ev", base, '{5'h14, 5'h16, 5'h1C, 5'h1D});
    chk("ovf_drained", {15'd0, ev_valid}, 16'd0);

    // Random backpressure, then reset in the middle of a scan
    button_state = 16'hFFFF;
    rand_ready(30);
    button_state = 16'h0FAF;
    guard = 0;
    while (m_pend == 0 && guard < 40) begin
      ev_ready = 1'($urandom_range(0, 1));
      cyc(1);
      guard++;
    end
    chk("scan_reached", {15'd0, m_pend != 0}, 16'd1);
    cyc(2);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    chk("mid_rst_valid", {15'd0, ev_valid}, 16'd0);
    chk("mid_rst_ovf", {15'd0, overflow}, 16'd0);
    chk("mid_rst_pressed", pressed, 16'h0000);
    rand_ready(30);
    ev_ready = 1'b1;
    cyc(10);
    chk("end_drained", {15'd0, ev_valid}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
